// File: rtl/clk_div_pkg.sv
// Shared state encoding and ratio helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned RATIO_WID_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_t;

  // Ratio 0 encodes 2^wid, so its terminal count is all-ones.
  function automatic int unsigned ratio_m1(input int unsigned r, input int unsigned wid);
    return (r == 0) ? ((32'd1 << wid) - 32'd1) : (r - 32'd1);
  endfunction

  function automatic int unsigned half(input int unsigned r, input int unsigned wid);
    return (r == 0) ? (32'd1 << (wid - 32'd1)) : (r >> 1);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: run/drain FSM, period counter, shadow ratio handshake,
// output flop and the bypass clock switch.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WID = RATIO_WID_DEF,
  parameter int unsigned RST_RATIO = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 testmode_i,
  input  logic                 en_i,
  input  logic                 sync_i,
  input  logic                 cfg_vld_i,
  output logic                 cfg_rdy_o,
  input  logic [RATIO_WID-1:0] cfg_ratio_i,
  output logic                 clk_o,
  output logic                 div_en_o,
  output logic                 busy_o
);

  ch_state_t            state_q, state_d;
  logic [RATIO_WID-1:0] cnt_q, cnt_d;
  logic [RATIO_WID-1:0] ratio_q, ratio_d;
  logic [RATIO_WID-1:0] shadow_q, shadow_d;
  logic                 pend_q, pend_d;
  logic                 div_q, div_d;
  logic [RATIO_WID-1:0] rm1, h_m1;
  logic                 at_end, run_sync, apply, bypass;

  assign rm1      = RATIO_WID'(ratio_m1(32'(ratio_q), RATIO_WID));
  assign h_m1     = RATIO_WID'(half(32'(ratio_q), RATIO_WID) - 32'd1);
  assign at_end   = (cnt_q >= rm1);
  assign run_sync = sync_i && (state_q == RUN);
  assign apply    = pend_q && ((state_q == IDLE) || at_end || run_sync);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = DRAIN;
      DRAIN:   if (en_i) state_d = RUN;
               else if (at_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != IDLE);
    div_en_o = (state_q == RUN) && at_end;
    bypass   = (state_q == RUN) && (ratio_q == RATIO_WID'(1));
  end

  // Output is set at the end of the low phase and cleared at every wrap, so a
  // ratio change or sync always restarts from a low phase.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    ratio_d  = ratio_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (cfg_vld_i && !pend_q) begin
      shadow_d = cfg_ratio_i;
      pend_d   = 1'b1;
    end
    if (apply) begin
      ratio_d = shadow_q;
      pend_d  = 1'b0;
    end
    if ((state_q == IDLE) || apply || run_sync || at_end) begin
      cnt_d = '0;
      div_d = 1'b0;
    end else begin
      cnt_d = cnt_q + RATIO_WID'(1);
      if (cnt_q == h_m1) div_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= 1'b0;
      ratio_q  <= RATIO_WID'(RST_RATIO);
      shadow_q <= RATIO_WID'(RST_RATIO);
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end

  assign cfg_rdy_o = !pend_q;

  // Bypass only changes at apply or FSM transitions, when div_q is already low.
  glitch_free_clk_switch #(.CLK_NUM(2)) u_clk_sw (
    .clk_i      ({clk_i, div_q}),
    .ref_clk_i  (clk_i),
    .rst_n      (rst_n),
    .testmode_i (testmode_i),
    .sel_i      (bypass),
    .clk_o      (clk_o)
  );

endmodule

// File: rtl/glitch_free_clk_switch.sv
// Clock selector whose select is retimed on the falling edge of the reference clock.
// testmode_i makes the select transparent so scan can drive the mux directly.
module glitch_free_clk_switch #(
  parameter int CLK_NUM = 2,
  parameter int SEL_W   = $clog2(CLK_NUM)
) (
  input  logic [CLK_NUM-1:0] clk_i,
  input  logic               ref_clk_i,
  input  logic               rst_n,
  input  logic               testmode_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic               clk_o
);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_eff;

  // Inputs only move on the rising edge, so switching while the reference is low is clean.
  always_ff @(negedge ref_clk_i or negedge rst_n) begin
    if (!rst_n) sel_q <= '0;
    else        sel_q <= sel_i;
  end

  assign sel_eff = testmode_i ? sel_i : sel_q;
  assign clk_o   = clk_i[sel_eff];

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel programmable integer clock divider.
// Optional CLK_DIV_SYNC_EN adds sync_pulse to realign all running channels.
module clk_div_mc
  import clk_div_pkg::*;
#(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned RATIO_WID = RATIO_WID_DEF,
  parameter int unsigned RST_RATIO = 2
) (
  input  logic                          i_clk,
  input  logic                          rst_n,
  input  logic                          testmode,
  input  logic [CH_NUM-1:0]             ch_en,
  input  logic [CH_NUM-1:0]             cfg_vld,
  output logic [CH_NUM-1:0]             cfg_rdy,
  input  logic [CH_NUM*RATIO_WID-1:0]   cfg_ratio,
  output logic [CH_NUM-1:0]             o_clk,
  output logic [CH_NUM-1:0]             div_en,
  output logic [CH_NUM-1:0]             ch_busy
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic                          sync_pulse
`endif
);

  logic sync_w;

`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync_pulse;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    clk_div_ch #(
      .RATIO_WID (RATIO_WID),
      .RST_RATIO (RST_RATIO)
    ) u_ch (
      .clk_i       (i_clk),
      .rst_n       (rst_n),
      .testmode_i  (testmode),
      .en_i        (ch_en[k]),
      .sync_i      (sync_w),
      .cfg_vld_i   (cfg_vld[k]),
      .cfg_rdy_o   (cfg_rdy[k]),
      .cfg_ratio_i (cfg_ratio[k*RATIO_WID +: RATIO_WID]),
      .clk_o       (o_clk[k]),
      .div_en_o    (div_en[k]),
      .busy_o      (ch_busy[k])
    );
  end

endmodule

// File: tb/tb_clk_div_mc.sv
// Bench for clk_div_mc: vector table of per-channel ratios plus hand-written
// sequences for hitless update, drain, bypass and asynchronous reset.
module tb_clk_div_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        testmode = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [3:0]  cfg_vld = '0;
  logic [3:0]  cfg_rdy;
  logic [31:0] cfg_ratio = '0;
  logic [3:0]  o_clk;
  logic [3:0]  div_en;
  logic [3:0]  ch_busy;
`ifdef CLK_DIV_SYNC_EN
  logic        sync_pulse = 1'b0;
`endif

  always #5 clk = ~clk;

  clk_div_mc dut (
    .i_clk     (clk),
    .rst_n     (rst_n),
    .testmode  (testmode),
    .ch_en     (ch_en),
    .cfg_vld   (cfg_vld),
    .cfg_rdy   (cfg_rdy),
    .cfg_ratio (cfg_ratio),
    .o_clk     (o_clk),
    .div_en    (div_en),
    .ch_busy   (ch_busy)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync_pulse(sync_pulse)
`endif
  );

  typedef struct { string name; integer exp; } exp_t;
  typedef struct { int ch; logic [7:0] ratio; int lo; int hi; } vec_t;

  exp_t   sb[$];
  vec_t   vt[6];
  int     n_vec = 0;
  int     n_bad = 0;

  task automatic sb_push(input string name, input integer v);
    sb.push_back('{name, v});
  endtask

  task automatic sb_check(input integer act);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty got=%0d want=none", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s got=%0d want=%0d", e.name, act, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic program_idle(input int ch, input logic [7:0] r);
    cfg_ratio[ch*8 +: 8] = r;
    cfg_vld[ch] = 1'b1;
    tick();
    cfg_vld[ch] = 1'b0;
    tick();
    tick();
  endtask

  // One full output period starting at a rising sample.
  task automatic measure(input int ch, output integer lo, output integer hi,
                         output integer dcnt, output integer dat);
    logic prev;
    bit   found;
    lo = -1; hi = -1; dcnt = -1; dat = -1;
    prev = o_clk[ch];
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      tick();
      if (!prev && o_clk[ch]) found = 1'b1;
      else prev = o_clk[ch];
    end
    if (found) begin
      lo = 0; hi = 0; dcnt = 0;
      for (int i = 0; i < 600; i++) begin
        if (o_clk[ch]) begin
          if (lo != 0) break;
          hi++;
        end else lo++;
        if (div_en[ch]) begin
          dcnt++;
          dat = i;
        end
        tick();
      end
    end
  endtask

  task automatic stop_and_check(input int ch, input string tag);
    integer dden;
    dden = 0;
    ch_en[ch] = 1'b0;
    sb_push({tag, "_drain_div_en"}, 0);
    sb_push({tag, "_busy_fall"}, 0);
    sb_push({tag, "_idle_oclk"}, 0);
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!ch_busy[ch]) break;
      if (div_en[ch]) dden++;
    end
    sb_check(dden);
    sb_check(ch_busy[ch]);
    sb_check(o_clk[ch]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    integer lo, hi, dcnt, dat, n, dlen, dhi, dden;
    vt[0] = '{0, 8'd4, 2, 2};
    vt[1] = '{1, 8'd0, 128, 128};
    vt[2] = '{2, 8'd5, 2, 3};
    vt[3] = '{0, 8'd3, 1, 2};
    vt[4] = '{2, 8'd2, 1, 1};
    vt[5] = '{3, 8'd8, 4, 4};

    #2;
    sb_push("rst_o_clk", 0);   sb_check(o_clk);
    sb_push("rst_div_en", 0);  sb_check(div_en);
    sb_push("rst_busy", 0);    sb_check(ch_busy);
    sb_push("rst_cfg_rdy", 15); sb_check(cfg_rdy);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      program_idle(vt[v].ch, vt[v].ratio);
      ch_en[vt[v].ch] = 1'b1;
      sb_push($sformatf("v%0d_low", v), vt[v].lo);
      sb_push($sformatf("v%0d_high", v), vt[v].hi);
      sb_push($sformatf("v%0d_div_en_count", v), 1);
      sb_push($sformatf("v%0d_div_en_pos", v), vt[v].hi - 1);
      measure(vt[v].ch, lo, hi, dcnt, dat);
      sb_check(lo); sb_check(hi); sb_check(dcnt); sb_check(dat);
      stop_and_check(vt[v].ch, $sformatf("v%0d", v));
    end

    // Bypass: o_clk follows i_clk, div_en every cycle.
    program_idle(3, 8'd1);
    ch_en[3] = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      sb_push("byp_high_phase", 1);
      sb_push("byp_div_en", 1);
      sb_check(o_clk[3]);
      sb_check(div_en[3]);
      @(negedge clk);
      #1;
      sb_push("byp_low_phase", 0);
      sb_check(o_clk[3]);
      tick();
    end
    stop_and_check(3, "byp");

    // Hitless update 4 -> 6 accepted at cnt=1; a second request is ignored.
    program_idle(0, 8'd4);
    ch_en[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (div_en[0]) break;
    end
    tick();
    tick();
    cfg_ratio[7:0] = 8'd6;
    cfg_vld[0] = 1'b1;
    sb_push("upd_rdy_after_accept", 0);
    tick();
    sb_check(cfg_rdy[0]);
    cfg_ratio[7:0] = 8'd7;
    sb_push("upd_rdy_pending", 0);
    sb_push("upd_div_en_cnt3", 1);
    tick();
    sb_check(cfg_rdy[0]);
    sb_check(div_en[0]);
    cfg_vld[0] = 1'b0;
    sb_push("upd_rdy_after_apply", 1);
    sb_push("upd_first_low", 3);
    tick();
    sb_check(cfg_rdy[0]);
    n = 0;
    for (int i = 0; i < 20 && !o_clk[0]; i++) begin
      n++;
      tick();
    end
    sb_check(n);
    sb_push("upd_low", 3); sb_push("upd_high", 3);
    sb_push("upd_div_en_count", 1); sb_push("upd_div_en_pos", 2);
    measure(0, lo, hi, dcnt, dat);
    sb_check(lo); sb_check(hi); sb_check(dcnt); sb_check(dat);

    // Ratio 8 while running, then drop ch_en during the high phase (cnt=5).
    cfg_ratio[7:0] = 8'd8;
    cfg_vld[0] = 1'b1;
    tick();
    cfg_vld[0] = 1'b0;
    for (int i = 0; i < 20 && !cfg_rdy[0]; i++) tick();
    for (int i = 0; i < 30 && !o_clk[0]; i++) tick();
    tick();
    ch_en[0] = 1'b0;
    dlen = 0; dhi = 0; dden = 0;
    sb_push("drain_len", 2); sb_push("drain_high", 2); sb_push("drain_div_en", 0);
    sb_push("drain_busy_fall", 0); sb_push("drain_end_low", 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!ch_busy[0]) break;
      dlen++;
      if (o_clk[0]) dhi++;
      if (div_en[0]) dden++;
    end
    sb_check(dlen); sb_check(dhi); sb_check(dden);
    sb_check(ch_busy[0]); sb_check(o_clk[0]);

    // Asynchronous reset mid-period with a pending ratio.
    program_idle(0, 8'd8);
    ch_en[0] = 1'b1;
    ch_en[2] = 1'b1;
    for (int i = 0; i < 30 && !o_clk[0]; i++) tick();
    tick();
    cfg_ratio[7:0] = 8'd3;
    cfg_vld[0] = 1'b1;
    sb_push("rst_pre_pending", 0);
    tick();
    cfg_vld[0] = 1'b0;
    sb_check(cfg_rdy[0]);
    #3;
    rst_n = 1'b0;
    #1;
    sb_push("arst_o_clk", 0);    sb_check(o_clk);
    sb_push("arst_div_en", 0);   sb_check(div_en);
    sb_push("arst_busy", 0);     sb_check(ch_busy);
    sb_push("arst_cfg_rdy", 15); sb_check(cfg_rdy);
    ch_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ch_en[0] = 1'b1;
    sb_push("arst_low", 1); sb_push("arst_high", 1);
    sb_push("arst_div_en_count", 1); sb_push("arst_div_en_pos", 0);
    measure(0, lo, hi, dcnt, dat);
    sb_check(lo); sb_check(hi); sb_check(dcnt); sb_check(dat);
    stop_and_check(0, "arst");

`ifdef CLK_DIV_SYNC_EN
    program_idle(0, 8'd4);
    program_idle(1, 8'd8);
    ch_en[0] = 1'b1;
    tick(); tick(); tick();
    ch_en[1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    sb_push("sync_ch0_low", 0); sb_push("sync_ch1_low", 0);
    sb_check(o_clk[0]); sb_check(o_clk[1]);
    lo = -1; hi = -1;
    for (int i = 0; i < 12; i++) begin
      if (o_clk[0] && lo < 0) lo = i;
      if (o_clk[1] && hi < 0) hi = i;
      tick();
    end
    sb_push("sync_ch0_rise", 2); sb_push("sync_ch1_rise", 4);
    sb_check(lo); sb_check(hi);
    ch_en = '0;
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
